ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 158 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter (open-drain via enables).
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RTS       = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;
    localparam logic [2:0] S_FINISH    = 3'd5;

    localparam logic [CNT_W-1:0] c_inhibit_start = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] c_inhibit_last  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       c_stop_bit      = 4'd10;
    localparam logic [3:0]       c_ack_bit       = 4'd11;

    logic             r_clk_s1;
    logic             r_clk_s2;
    logic             r_clk_prev;
    logic             r_data_s1;
    logic             r_data_s2;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit_cnt;
    logic [9:0]       r_frame;
    logic             r_ack_ok;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_done;
    logic             r_err;
    logic             w_fall;
    logic             w_timeout;

    // Idle-high reset values keep a reset from looking like a clock fall.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= ps2_data;
            r_data_s2  <= r_data_s1;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_timeout = (r_cnt == c_timeout_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_frame   <= '0;
            r_ack_ok  <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        // Frame bits in line order: data LSB first, odd parity, stop.
                        r_frame  <= {1'b1, ~^tx_data, tx_data};
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b1;
                        r_state  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_inhibit_start) begin
                        r_data_oe <= 1'b1;
                    end
                    if (r_cnt == c_inhibit_last) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b1;
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_RTS;
                    end
                end
                S_RTS, S_SEND, S_WAIT_IDLE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_timeout) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_FINISH;
                    end else if (r_state == S_WAIT_IDLE) begin
                        if (r_clk_s2 && r_data_s2) begin
                            r_done  <= r_ack_ok;
                            r_err   <= ~r_ack_ok;
                            r_state <= S_FINISH;
                        end
                    end else if (w_fall) begin
                        if (r_bit_cnt == c_stop_bit) begin
                            r_ack_ok  <= ~r_data_s2;
                            r_bit_cnt <= c_ack_bit;
                            r_state   <= S_WAIT_IDLE;
                        end else begin
                            r_data_oe <= ~r_frame[r_bit_cnt];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_state   <= S_SEND;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = (r_state == S_IDLE);
    assign tx_busy     = ~tx_ready;
    assign tx_done     = r_done;
    assign tx_err      = r_err;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Brief    : Self-checking bench for ps2_host_tx with a behavioural PS/2 device.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int unsigned c_inhibit = 5000;
    localparam int unsigned c_timeout = 2000;
    localparam int          c_half    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       w_ps2_clk;
    logic       w_ps2_data;

    // Open-drain bus: either side pulling low wins.
    assign w_ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign w_ps2_data = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(c_inhibit),
        .TIMEOUT_CYCLES(c_timeout),
        .CNT_W(20)
    ) dut (
        .clock(clk),
        .reset(rst),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .ps2_clk(w_ps2_clk),
        .ps2_data(w_ps2_data),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    int unsigned n_done = 0;
    int unsigned n_err = 0;
    int unsigned n_both = 0;
    int unsigned n_clk_oe = 0;
    int unsigned n_overlap = 0;
    bit          dev_active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done) n_done <= n_done + 1;
        if (tx_err) n_err <= n_err + 1;
        if (tx_done && tx_err) n_both <= n_both + 1;
        if (ps2_clk_oe) n_clk_oe <= n_clk_oe + 1;
        if (ps2_clk_oe && ps2_data_oe) n_overlap <= n_overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line levels a device should see after falls 1..10.
    function automatic logic [9:0] frame_model(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d};
    endfunction

    // mode: 0 = ACK, 1 = no ACK, 2 = silent, 3 = stop after fall 5 holding clock low
    task automatic dev_run(input int mode, output logic [9:0] seen,
                           output int unsigned rts_cyc, output bit found);
        seen = '0;
        found = 1'b0;
        rts_cyc = 0;
        for (int i = 0; i < int'(c_inhibit) + 200 && !found; i++) begin
            @(negedge clk);
            if (ps2_data_oe && !ps2_clk_oe) begin
                found = 1'b1;
                rts_cyc = cyc;
            end
        end
        if (!found || mode == 2) return;
        for (int n = 1; n <= 11; n++) begin
            if (n == 11 && mode == 0) dev_data_low = 1'b1;
            repeat (c_half) @(negedge clk);
            dev_clk_low = 1'b1;
            if (mode == 3 && n == 5) begin
                repeat (6) @(negedge clk);
                return;
            end
            repeat (c_half) @(negedge clk);
            if (n <= 10) seen[n-1] = w_ps2_data;
            dev_clk_low = 1'b0;
            if (n == 11) dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_pulse(output bit got);
        got = 1'b0;
        for (int i = 0; i < int'(c_timeout) + 100 && !got; i++) begin
            @(negedge clk);
            if (tx_done || tx_err) got = 1'b1;
        end
    endtask

    task automatic check_pulse(input bit got, input bit exp_ok);
        chk("pulse_seen", 32'(got), 32'd1);
        chk("done_level", 32'(tx_done), 32'(exp_ok));
        chk("err_level", 32'(tx_err), 32'(!exp_ok));
        chk("oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("ready_in_pulse", 32'(tx_ready), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] d, input int mode);
        logic [9:0]  seen;
        int unsigned rts;
        int unsigned oe0, ov0, d0, e0;
        bit          found, got;
        @(negedge clk);
        chk("ready_before", 32'(tx_ready), 32'd1);
        oe0 = n_clk_oe; ov0 = n_overlap; d0 = n_done; e0 = n_err;
        tx_valid = 1'b1;
        tx_data = d;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
        chk("busy_after_accept", 32'(tx_busy), 32'd1);
        dev_run(mode, seen, rts, found);
        chk("rts_seen", 32'(found), 32'd1);
        chk("frame", 32'(seen), 32'(frame_model(d)));
        wait_pulse(got);
        check_pulse(got, mode == 0);
        @(negedge clk);
        chk("ready_after", 32'(tx_ready), 32'd1);
        chk("busy_after", 32'(tx_busy), 32'd0);
        @(negedge clk);
        chk("clk_oe_cycles", n_clk_oe - oe0, c_inhibit);
        chk("start_overlap", n_overlap - ov0, 32'd1);
        chk("done_count", n_done - d0, 32'(mode == 0));
        chk("err_count", n_err - e0, 32'(mode != 0));
    endtask

    initial begin
        logic [9:0]  seen_a, seen_b;
        logic [7:0]  a, b;
        int unsigned rts, d0, e0, oe0;
        bit          found, got;

        repeat (3) @(negedge clk);
        chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("rst_pulses", 32'({tx_done, tx_err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);

        send_byte(8'hED, 0);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        for (int k = 0; k < 3; k++) send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 1);

        // Silent device: timeout measured from the first RTS cycle.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'($urandom);
        @(negedge clk);
        tx_valid = 1'b0;
        dev_run(2, seen_a, rts, found);
        chk("to_rts_seen", 32'(found), 32'd1);
        wait_pulse(got);
        check_pulse(got, 1'b0);
        chk("to_latency", cyc - rts, c_timeout);
        @(negedge clk);
        chk("to_ready_after", 32'(tx_ready), 32'd1);

        // Reset in the middle of the frame.
        tx_valid = 1'b1;
        tx_data = 8'($urandom);
        @(negedge clk);
        tx_valid = 1'b0;
        dev_run(3, seen_a, rts, found);
        d0 = n_done; e0 = n_err;
        rst = 1'b1;
        dev_clk_low = 1'b0;
        @(negedge clk);
        chk("midrst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("midrst_pulses", 32'({tx_done, tx_err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(tx_ready), 32'd1);
        oe0 = n_clk_oe;
        repeat (50) @(negedge clk);
        chk("midrst_no_pulse", (n_done - d0) + (n_err - e0), 32'd0);
        chk("midrst_no_clk_oe", n_clk_oe - oe0, 32'd0);
        send_byte(8'($urandom), 0);

        // tx_valid held high with changing data: only the latched byte goes out.
        a = 8'($urandom);
        b = 8'($urandom);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = a;
        @(negedge clk);
        dev_active = 1'b1;
        fork
            begin
                dev_run(0, seen_a, rts, found);
                dev_active = 1'b0;
            end
            begin
                while (dev_active) begin
                    tx_data = 8'($urandom);
                    @(negedge clk);
                end
            end
        join
        tx_data = b;
        chk("hold_frame_a", 32'(seen_a), 32'(frame_model(a)));
        wait_pulse(got);
        check_pulse(got, 1'b1);
        @(negedge clk);
        chk("hold_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        chk("hold_second_accept", 32'(tx_busy), 32'd1);
        tx_valid = 1'b0;
        dev_run(0, seen_b, rts, found);
        chk("hold_frame_b", 32'(seen_b), 32'(frame_model(b)));
        wait_pulse(got);
        check_pulse(got, 1'b1);
        repeat (2) @(negedge clk);
        chk("never_both_pulses", n_both, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got no completion, expected finish before 95000 cycles");
        $fatal(1);
    end

endmodule
`default_nettype wire
